// File: rtl/snitch_fpu_arbiter_pkg.sv
// Shared constants and helpers for the FPU sharing arbiter.
// Imported by the arbiter top and its credit counters.
package snitch_fpu_arbiter_pkg;

    localparam int unsigned NumFpuShare = 2;
    localparam int unsigned CreditWidth = 4;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/snitch_fpu_arbiter_credit.sv
// Per-requester in-flight counter: up on issue, down on response.
// Saturates at zero; a response with nothing outstanding is illegal.
module snitch_fpu_arbiter_credit
    import snitch_fpu_arbiter_pkg::*;
#(
    parameter int unsigned MaxCnt = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic dec_i,
    output logic at_max_o,
    output logic nonzero_o
);

    logic [CreditWidth-1:0] cnt_q, cnt_d;

    assign at_max_o  = cnt_q >= CreditWidth'(MaxCnt);
    assign nonzero_o = cnt_q != '0;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({inc_i, dec_i})
            2'b10: if (!at_max_o) cnt_d = cnt_q + 1'b1;
            2'b01: if (nonzero_o) cnt_d = cnt_q - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    underflow_chk : assert property (
        @(posedge clk_i) disable iff (!rst_ni) dec_i |-> nonzero_o
    );

endmodule

// File: rtl/snitch_fpu_arbiter.sv
// Round-robin arbiter sharing one FPU between NumReq cores, with
// grant lock under back-pressure and tag-based response routing.
module snitch_fpu_arbiter
    import snitch_fpu_arbiter_pkg::*;
#(
    parameter int unsigned NumReq         = 2,
    parameter int unsigned ReqWidth       = 256,
    parameter int unsigned RspWidth       = 69,
    parameter int unsigned TagWidth       = 8,
    parameter int unsigned MaxOutstanding = 4,
    localparam int unsigned IdxWidth      = idx_width(NumReq)
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NumReq-1:0]                   req_valid_i,
    output logic [NumReq-1:0]                   req_ready_o,
    input  logic [NumReq-1:0][ReqWidth-1:0]     req_data_i,
    input  logic [NumReq-1:0][TagWidth-1:0]     req_tag_i,
    output logic                                fpu_valid_o,
    input  logic                                fpu_ready_i,
    output logic [ReqWidth-1:0]                 fpu_data_o,
    output logic [TagWidth+IdxWidth-1:0]        fpu_tag_o,
    input  logic                                fpu_rsp_valid_i,
    output logic                                fpu_rsp_ready_o,
    input  logic [RspWidth-1:0]                 fpu_rsp_data_i,
    input  logic [TagWidth+IdxWidth-1:0]        fpu_rsp_tag_i,
    output logic [NumReq-1:0]                   rsp_valid_o,
    input  logic [NumReq-1:0]                   rsp_ready_i,
    output logic [NumReq-1:0][RspWidth-1:0]     rsp_data_o,
    output logic [NumReq-1:0][TagWidth-1:0]     rsp_tag_o,
    output logic                                busy_o
);

    typedef struct packed {
        logic [IdxWidth-1:0] idx;
        logic [TagWidth-1:0] tag;
    } fpu_tag_t;

    logic [IdxWidth-1:0] ptr_q, lock_idx_q, grant;
    logic                lock_q, found, issue;
    logic [IdxWidth:0]   cand;
    logic [NumReq-1:0]   eligible, at_max, nonzero, inc, dec;
    fpu_tag_t            rsp_tag;
    logic                rsp_idx_ok;

    assign eligible = req_valid_i & ~at_max;

    // Search from ptr with wrap; a held lock overrides the search.
    always_comb begin
        found = 1'b0;
        grant = ptr_q;
        cand  = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            cand = {1'b0, ptr_q} + (IdxWidth+1)'(k);
            if (cand >= (IdxWidth+1)'(NumReq)) begin
                cand = cand - (IdxWidth+1)'(NumReq);
            end
            if (!found && eligible[cand[IdxWidth-1:0]]) begin
                found = 1'b1;
                grant = cand[IdxWidth-1:0];
            end
        end
        if (lock_q) begin
            found = 1'b1;
            grant = lock_idx_q;
        end
    end

    assign fpu_valid_o = found;
    assign fpu_data_o  = req_data_i[grant];
    assign fpu_tag_o   = fpu_tag_t'{idx: grant, tag: req_tag_i[grant]};
    assign issue       = fpu_valid_o & fpu_ready_i;

    assign rsp_tag    = fpu_tag_t'(fpu_rsp_tag_i);
    assign rsp_idx_ok = {1'b0, rsp_tag.idx} < (IdxWidth+1)'(NumReq);
    assign fpu_rsp_ready_o = rsp_idx_ok & rsp_ready_i[rsp_tag.idx];

    for (genvar i = 0; i < NumReq; i++) begin : gen_req
        assign req_ready_o[i] = issue & (grant == IdxWidth'(i));
        assign inc[i]         = req_ready_o[i];
        assign rsp_valid_o[i] = fpu_rsp_valid_i & rsp_idx_ok
                              & (rsp_tag.idx == IdxWidth'(i));
        assign dec[i]         = rsp_valid_o[i] & rsp_ready_i[i];
        assign rsp_data_o[i]  = fpu_rsp_data_i;
        assign rsp_tag_o[i]   = rsp_tag.tag;

        snitch_fpu_arbiter_credit #(
            .MaxCnt (MaxOutstanding)
        ) i_credit (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .inc_i     (inc[i]),
            .dec_i     (dec[i]),
            .at_max_o  (at_max[i]),
            .nonzero_o (nonzero[i])
        );
    end

    assign busy_o = |nonzero;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            lock_q <= fpu_valid_o & ~fpu_ready_i;
            if (fpu_valid_o && !fpu_ready_i) begin
                lock_idx_q <= grant;
            end
            if (issue) begin
                ptr_q <= (grant == IdxWidth'(NumReq - 1))
                       ? '0 : grant + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_snitch_fpu_arbiter.sv
// Scoreboard bench for snitch_fpu_arbiter with two requesters.
// Issue and response expectations are queued as stimulus is driven.
module tb_snitch_fpu_arbiter;

    localparam int NR = 2;
    localparam int RW = 32;
    localparam int SW = 16;
    localparam int TW = 8;
    localparam int IW = 1;
    localparam logic [RW-1:0] D0 = 32'hA0A0_0001;
    localparam logic [RW-1:0] D1 = 32'hB1B1_0002;

    logic clk = 1'b0;
    logic rst_n;
    logic [NR-1:0]          req_valid;
    logic [NR-1:0]          req_ready_o;
    logic [NR-1:0][RW-1:0]  req_data;
    logic [NR-1:0][TW-1:0]  req_tag;
    logic                   fpu_valid_o;
    logic                   fpu_ready;
    logic [RW-1:0]          fpu_data_o;
    logic [TW+IW-1:0]       fpu_tag_o;
    logic                   fpu_rsp_valid;
    logic                   fpu_rsp_ready_o;
    logic [SW-1:0]          fpu_rsp_data;
    logic [TW+IW-1:0]       fpu_rsp_tag;
    logic [NR-1:0]          rsp_valid_o;
    logic [NR-1:0]          rsp_ready;
    logic [NR-1:0][SW-1:0]  rsp_data_o;
    logic [NR-1:0][TW-1:0]  rsp_tag_o;
    logic                   busy_o;

    int checks = 0;
    int failures = 0;

    logic [IW+TW+RW-1:0] iss_q[$];
    logic [IW+TW+SW-1:0] rsp_q[$];
    logic [IW+TW+RW-1:0] iss_exp;
    logic [IW+TW+SW-1:0] rsp_exp;

    always #5 clk = ~clk;

    snitch_fpu_arbiter #(
        .NumReq         (NR),
        .ReqWidth       (RW),
        .RspWidth       (SW),
        .TagWidth       (TW),
        .MaxOutstanding (4)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready_o),
        .req_data_i      (req_data),
        .req_tag_i       (req_tag),
        .fpu_valid_o     (fpu_valid_o),
        .fpu_ready_i     (fpu_ready),
        .fpu_data_o      (fpu_data_o),
        .fpu_tag_o       (fpu_tag_o),
        .fpu_rsp_valid_i (fpu_rsp_valid),
        .fpu_rsp_ready_o (fpu_rsp_ready_o),
        .fpu_rsp_data_i  (fpu_rsp_data),
        .fpu_rsp_tag_i   (fpu_rsp_tag),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_ready_i     (rsp_ready),
        .rsp_data_o      (rsp_data_o),
        .rsp_tag_o       (rsp_tag_o),
        .busy_o          (busy_o)
    );

    // Scoreboard: pop on every issue and response handshake.
    always @(negedge clk) begin
        if (rst_n && fpu_valid_o && fpu_ready) begin
            checks++;
            if (iss_q.size() == 0) begin
                failures++;
                $display("FAIL issue_unexpected got=%h_%h want=none",
                         fpu_tag_o, fpu_data_o);
            end else begin
                iss_exp = iss_q.pop_front();
                if ({fpu_tag_o, fpu_data_o} !== iss_exp) begin
                    failures++;
                    $display("FAIL issue got=%h want=%h",
                             {fpu_tag_o, fpu_data_o}, iss_exp);
                end
            end
        end
        for (int i = 0; i < NR; i++) begin
            if (rst_n && rsp_valid_o[i] && rsp_ready[i]) begin
                checks++;
                if (rsp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rsp_unexpected idx=%0d got=%h", i,
                             rsp_data_o[i]);
                end else begin
                    rsp_exp = rsp_q.pop_front();
                    if ({1'(i), rsp_tag_o[i], rsp_data_o[i]} !== rsp_exp) begin
                        failures++;
                        $display("FAIL rsp got=%h want=%h",
                                 {1'(i), rsp_tag_o[i], rsp_data_o[i]},
                                 rsp_exp);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_rsp(input logic idx, input logic [TW-1:0] tag,
                            input logic [SW-1:0] data);
        rsp_q.push_back({idx, tag, data});
        fpu_rsp_valid = 1'b1;
        fpu_rsp_tag   = {idx, tag};
        fpu_rsp_data  = data;
        step();
        fpu_rsp_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '0;
        req_data = '0;
        req_tag = '0;
        fpu_ready = 1'b0;
        fpu_rsp_valid = 1'b0;
        fpu_rsp_data = '0;
        fpu_rsp_tag = '0;
        rsp_ready = '0;
        repeat (2) step();
        @(negedge clk);
        checks++;
        if ({fpu_valid_o, req_ready_o, rsp_valid_o, busy_o} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=000000",
                     {fpu_valid_o, req_ready_o, rsp_valid_o, busy_o});
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_round_robin();
        req_data[0] = D0;
        req_data[1] = D1;
        req_tag[0] = 8'h11;
        req_tag[1] = 8'h22;
        fpu_ready = 1'b1;
        rsp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            iss_q.push_back((k % 2) ? {1'b1, 8'h22, D1} : {1'b0, 8'h11, D0});
        end
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (req_ready_o !== ((k % 2) ? 2'b10 : 2'b01)) begin
                failures++;
                $display("FAIL rr_grant k=%0d got=%b want=%b", k,
                         req_ready_o, (k % 2) ? 2'b10 : 2'b01);
            end
            step();
        end
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b1) begin
            failures++;
            $display("FAIL rr_busy got=%b want=1", busy_o);
        end
        step();
        send_rsp(1'b0, 8'h11, 16'h1000);
        send_rsp(1'b1, 8'h22, 16'h1001);
        send_rsp(1'b0, 8'h11, 16'h1002);
        send_rsp(1'b1, 8'h22, 16'h1003);
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL rr_idle got=%b want=0", busy_o);
        end
        step();
    endtask

    task automatic test_lock();
        iss_q.push_back({1'b1, 8'h22, D1});
        iss_q.push_back({1'b0, 8'h11, D0});
        req_valid = 2'b10;
        fpu_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({fpu_valid_o, req_ready_o, fpu_tag_o, fpu_data_o}
                    !== {1'b1, 2'b00, 1'b1, 8'h22, D1}) begin
                failures++;
                $display("FAIL lock_hold c=%0d got=%h want=%h", c,
                         {fpu_valid_o, req_ready_o, fpu_tag_o, fpu_data_o},
                         {1'b1, 2'b00, 1'b1, 8'h22, D1});
            end
            step();
            req_valid = 2'b11;
        end
        fpu_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready_o !== 2'b10) begin
            failures++;
            $display("FAIL lock_release got=%b want=10", req_ready_o);
        end
        step();
        @(negedge clk);
        checks++;
        if (req_ready_o !== 2'b01) begin
            failures++;
            $display("FAIL lock_next got=%b want=01", req_ready_o);
        end
        step();
        req_valid = '0;
        send_rsp(1'b1, 8'h22, 16'h1100);
        send_rsp(1'b0, 8'h11, 16'h1101);
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL lock_idle got=%b want=0", busy_o);
        end
        step();
    endtask

    task automatic test_credit_limit();
        for (int k = 0; k < 4; k++) iss_q.push_back({1'b0, 8'h11, D0});
        req_valid = 2'b01;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (req_ready_o !== 2'b01) begin
                failures++;
                $display("FAIL credit_fill k=%0d got=%b want=01", k,
                         req_ready_o);
            end
            step();
        end
        iss_q.push_back({1'b1, 8'h22, D1});
        req_valid = 2'b11;
        @(negedge clk);
        checks++;
        if (req_ready_o !== 2'b10) begin
            failures++;
            $display("FAIL credit_skip got=%b want=10", req_ready_o);
        end
        step();
        req_valid = 2'b01;
        rsp_q.push_back({1'b0, 8'h11, 16'h2000});
        fpu_rsp_valid = 1'b1;
        fpu_rsp_tag = {1'b0, 8'h11};
        fpu_rsp_data = 16'h2000;
        @(negedge clk);
        checks++;
        if ({fpu_valid_o, req_ready_o} !== 3'b000) begin
            failures++;
            $display("FAIL credit_masked got=%b want=000",
                     {fpu_valid_o, req_ready_o});
        end
        step();
        fpu_rsp_valid = 1'b0;
        iss_q.push_back({1'b0, 8'h11, D0});
        @(negedge clk);
        checks++;
        if (req_ready_o !== 2'b01) begin
            failures++;
            $display("FAIL credit_reenable got=%b want=01", req_ready_o);
        end
        step();
        req_valid = '0;
        for (int k = 0; k < 4; k++) send_rsp(1'b0, 8'h11, 16'(16'h2100 + k));
        send_rsp(1'b1, 8'h22, 16'h2200);
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL credit_idle got=%b want=0", busy_o);
        end
        step();
    endtask

    task automatic test_same_cycle();
        for (int k = 0; k < 3; k++) iss_q.push_back({1'b1, 8'h22, D1});
        req_valid = 2'b10;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (req_ready_o !== 2'b10) begin
                failures++;
                $display("FAIL same_fill k=%0d got=%b want=10", k,
                         req_ready_o);
            end
            step();
        end
        rsp_q.push_back({1'b1, 8'h22, 16'h3000});
        fpu_rsp_valid = 1'b1;
        fpu_rsp_tag = {1'b1, 8'h22};
        fpu_rsp_data = 16'h3000;
        @(negedge clk);
        checks++;
        if ({req_ready_o, rsp_valid_o, fpu_rsp_ready_o} !== 5'b10101) begin
            failures++;
            $display("FAIL same_both got=%b want=10101",
                     {req_ready_o, rsp_valid_o, fpu_rsp_ready_o});
        end
        step();
        fpu_rsp_valid = 1'b0;
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b1) begin
            failures++;
            $display("FAIL same_busy got=%b want=1", busy_o);
        end
        step();
        send_rsp(1'b1, 8'h22, 16'h3001);
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b1) begin
            failures++;
            $display("FAIL same_cnt2 got=%b want=1", busy_o);
        end
        step();
        send_rsp(1'b1, 8'h22, 16'h3002);
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL same_idle got=%b want=0", busy_o);
        end
        step();
    endtask

    task automatic test_rsp_backpressure();
        req_tag[1] = 8'h5A;
        iss_q.push_back({1'b1, 8'h5A, D1});
        req_valid = 2'b10;
        step();
        req_valid = '0;
        rsp_ready = 2'b01;
        fpu_rsp_valid = 1'b1;
        fpu_rsp_tag = {1'b1, 8'h5A};
        fpu_rsp_data = 16'h5A5A;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid_o, fpu_rsp_ready_o, rsp_tag_o[1], rsp_data_o[0],
                 busy_o} !== {2'b10, 1'b0, 8'h5A, 16'h5A5A, 1'b1}) begin
                failures++;
                $display("FAIL bp_stall c=%0d got=%h want=%h", c,
                         {rsp_valid_o, fpu_rsp_ready_o, rsp_tag_o[1],
                          rsp_data_o[0], busy_o},
                         {2'b10, 1'b0, 8'h5A, 16'h5A5A, 1'b1});
            end
            step();
        end
        rsp_q.push_back({1'b1, 8'h5A, 16'h5A5A});
        rsp_ready = 2'b11;
        @(negedge clk);
        checks++;
        if (fpu_rsp_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL bp_ready got=%b want=1", fpu_rsp_ready_o);
        end
        step();
        fpu_rsp_valid = 1'b0;
        req_tag[1] = 8'h22;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL bp_idle got=%b want=0", busy_o);
        end
        step();
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) iss_q.push_back({1'b0, 8'h11, D0});
        req_valid = 2'b01;
        repeat (3) step();
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_busy got=%b want=1", busy_o);
        end
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy_o, fpu_valid_o} !== 2'b00) begin
            failures++;
            $display("FAIL rstmid_clear got=%b want=00",
                     {busy_o, fpu_valid_o});
        end
        step();
        iss_q.push_back({1'b0, 8'h11, D0});
        req_valid = 2'b11;
        @(negedge clk);
        checks++;
        if (req_ready_o !== 2'b01) begin
            failures++;
            $display("FAIL rstmid_ptr got=%b want=01", req_ready_o);
        end
        step();
        req_valid = '0;
        send_rsp(1'b0, 8'h11, 16'h4000);
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_idle got=%b want=0", busy_o);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_lock();
        test_credit_limit();
        test_same_cycle();
        test_rsp_backpressure();
        test_reset_mid();
        checks++;
        if (iss_q.size() != 0 || rsp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d/%0d want=0/0", iss_q.size(),
                     rsp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
